seq_detect: RTL and testbench
=============================

# seq_detect

Serial bit-stream pattern detector. Samples one bit per clock from `din` when `din_vld` is high and pulses `result` for one cycle each time the last five valid bits equal `10010` (first-received bit first). Overlapping matches are detected. Sits downstream of a serial data source as a standalone detector; `result` is a registered single-cycle flag.

## Interface
- No parameters; the pattern `10010` and the 5-bit length are fixed.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `din`  input  1  serial data bit, sampled on the rising edge of `clk`.
- `din_vld`  input  1  qualifier; `din` is consumed only when high.
- `result`  output  1  registered match flag; high for one cycle per detected match.

## Operation
- Moore-style FSM with five states, encoding the longest pattern prefix matched so far:
  - S0: none.
  - S1: `1`.
  - S2: `10`.
  - S3: `100`.
  - S4: `1001`.
- Transitions, taken only on edges where `din_vld`=1:
  - S0: `din`=1 -> S1; `din`=0 -> S0.
  - S1: 1 -> S1; 0 -> S2.
  - S2: 1 -> S1; 0 -> S3.
  - S3: 1 -> S4; 0 -> S0.
  - S4: 0 -> S2 and match; 1 -> S1.
- Overlap: after a match, the trailing `10` is kept (next state S2), so `10010010` yields two matches.
- `din_vld`=0:
  - state holds;
  - the bit is ignored and does not break a partial match;
  - `result` is 0 that cycle.
- `result` is a register:
  - set to 1 on the edge where S4 receives a valid `din`=0;
  - cleared to 0 on every other edge.
- No other outputs, counters or sticky flags.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - state = S0, `result` = 0 immediately, independent of `clk`;
  - held while `rst_n` is low.
- After reset deassertion, the first rising edge with `din_vld`=1 samples the first bit.
- Latency: the final pattern bit is sampled on edge k, and `result` is high from edge k until edge k+1 (one full clock).
- Back-to-back matches:
  - minimum spacing is 3 valid bits (overlap distance);
  - `result` pulses never merge, except as separate one-cycle pulses with a low cycle between them.
- Reset mid-pattern discards any partial match; a pattern straddling reset is not detected.
- `din`/`din_vld` must be stable around the rising edge; no combinational path from inputs to `result`.

## Test plan
- Reset behaviour:
  - stimulus: hold `rst_n`=0 for 2 cycles while `din_vld`=1 and `din` toggles;
  - required: `result`=0 throughout, and the state starts in S0 after release.
- Single match:
  - stimulus: after reset, with `din_vld`=1, drive `1,0,0,1,0`;
  - required: `result`=1 for exactly the one cycle after the 5th bit's edge, 0 otherwise.
- Overlap:
  - stimulus: drive `1,0,0,1,0,0,1,0`;
  - required: `result` pulses after bit 5 and after bit 8 (two pulses, each one cycle wide).
- Near misses:
  - stimulus: drive `1,0,0,0,1,0,1,0,1,1,0,0,1,1`;
  - required: `result` stays 0 throughout.
- Valid gating:
  - stimulus: drive `1,0,0,1` with `din_vld`=1, then 2 cycles with `din_vld`=0 and `din`=1, then `0` with `din_vld`=1;
  - required: one `result` pulse, in the cycle after the final valid bit's edge.
- 18-bit stream:
  - stimulus: `1,0,0,1,0,0,1,0,1,1,0,0,1,0,0,0,1,0` with `din_vld`=1 throughout;
  - required: pulses after bits 5, 8 and 14 only.

Source files
------------

// File: rtl/seq_detect.sv
// Serial detector for the bit pattern 10010 (first-received bit first), with overlap.
// The state records the longest matched prefix; the match flag is registered.
module seq_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic din_vld,
  output logic result
);

  localparam logic [2:0] S0 = 3'd0;  // no prefix
  localparam logic [2:0] S1 = 3'd1;  // "1"
  localparam logic [2:0] S2 = 3'd2;  // "10"
  localparam logic [2:0] S3 = 3'd3;  // "100"
  localparam logic [2:0] S4 = 3'd4;  // "1001"

  logic [2:0] state_q, state_d;
  logic       result_q, result_d;

  always_comb begin
    state_d  = state_q;
    result_d = 1'b0;
    if (din_vld) begin
      case (state_q)
        S0: state_d = din ? S1 : S0;
        S1: state_d = din ? S1 : S2;
        S2: state_d = din ? S1 : S3;
        S3: state_d = din ? S4 : S0;
        S4: begin
          // A match keeps the trailing "10" so overlapping patterns are seen.
          state_d  = din ? S1 : S2;
          result_d = ~din;
        end
        default: state_d = S0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S0;
      result_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_seq_detect.sv
// Directed bench for seq_detect: a driver queues the expected flag for each clock,
// a monitor pops and compares one entry after every rising edge.
module tb_seq_detect;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0;
  logic din_vld = 1'b0;
  logic result;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;

  logic  exp_q[$];
  string tag_q[$];

  seq_detect u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .din_vld (din_vld),
    .result  (result)
  );

  always #5 clk = ~clk;

  // Monitor: one expected value per rising edge, checked 1 ns after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        logic  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_tests++;
        if (result !== e) begin
          n_fail++;
          $display("FAIL %s (cycle %0d): result=%b expected=%b", t, cyc, result, e);
        end
      end
    end
  end

  // Drive one clock's inputs at the falling edge and queue the flag expected after the next rising edge.
  task automatic step(input logic r, input logic d, input logic v, input logic e, input string t);
    @(negedge clk);
    rst_n   = r;
    din     = d;
    din_vld = v;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  // Vectors are MSB-first: bit n-1 is driven first.
  task automatic run_vec(input string t, input int n, input logic [31:0] d,
                         input logic [31:0] v, input logic [31:0] e);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, d[i], v[i], e[i], t);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, "idle");
  endtask

  initial begin
    // Reset held low with valid, toggling data: flag must stay low.
    #1;
    n_tests++;
    if (result !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: result=%b expected=0", result);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, "reset_hold");
    step(1'b0, 1'b0, 1'b1, 1'b0, "reset_hold");
    step(1'b0, 1'b1, 1'b1, 1'b0, "reset_hold");

    // First valid bit after release starts from S0.
    run_vec("single", 5, 32'b10010, 32'b11111, 32'b00001);
    idle(2);
    run_vec("overlap", 8, 32'b10010010, 32'b11111111, 32'b00001001);
    idle(2);
    run_vec("near_miss", 14, 32'b10001010110011, 32'h3fff, 32'b0);
    idle(2);
    run_vec("vld_gate", 7, 32'b1001110, 32'b1111001, 32'b0000001);
    idle(2);
    run_vec("stream18", 18, 32'b100100101100100010, 32'h3ffff,
            32'b000010010000010000);
    idle(2);

    // Asynchronous reset while the flag is high clears it without a clock edge.
    run_vec("pre_rst", 5, 32'b10010, 32'b11111, 32'b00001);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (result !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: result=%b expected=0", result);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, "reset_mid");
    // Had the "10" tail survived reset, 0,1,0 would complete a match.
    run_vec("post_rst", 3, 32'b010, 32'b111, 32'b000);

    // Partial prefix before reset is discarded.
    run_vec("straddle_a", 3, 32'b100, 32'b111, 32'b000);
    step(1'b0, 1'b1, 1'b1, 1'b0, "reset_straddle");
    run_vec("straddle_b", 2, 32'b10, 32'b11, 32'b00);
    idle(3);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
